// File: rtl/captura_nota.sv
// Input capture for the note classifier. It synchronizes the button and note switches,
// debounces the button, and registers one note code per confirmed press.
module captura_nota #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Botao,
  input  logic       Tom_sw,
  input  logic       A_sw,
  input  logic       B_sw,
  input  logic       C_sw,
  output logic       Pronto,
  output logic       Tom_input,
  output logic       A_input,
  output logic       B_input,
  output logic       C_input,
  output logic       Fim_palavra,
  output logic [3:0] Num_notas
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] DEB_PRESS   = 2'd1;
  localparam logic [1:0] PRESSED     = 2'd2;
  localparam logic [1:0] DEB_RELEASE = 2'd3;

  logic [1:0]    btnSync_q;
  logic [3:0]    noteMeta_q, noteSync_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pronto_q, pronto_d;
  logic          fim_q, fim_d;
  logic [3:0]    note_q, note_d;
  logic [3:0]    num_q, num_d;
  logic          bS;
  logic          capture;
  logic          isSeparator;

  assign bS          = btnSync_q[1];
  // Tom is deliberately excluded: only A, B and C decide a word separator.
  assign isSeparator = (noteSync_q[2:0] == 3'b000);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bS) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (!bS) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!bS) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end
      end
      DEB_RELEASE: begin
        if (bS) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pronto_d = capture;
    fim_d    = capture && isSeparator;
    note_d   = note_q;
    num_d    = num_q;
    if (capture) begin
      note_d = noteSync_q;
      if (isSeparator) begin
        num_d = 4'd0;
      end else if (num_q != 4'd15) begin
        num_d = num_q + 4'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      btnSync_q  <= '0;
      noteMeta_q <= '0;
      noteSync_q <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      pronto_q   <= 1'b0;
      fim_q      <= 1'b0;
      note_q     <= '0;
      num_q      <= '0;
    end else begin
      btnSync_q  <= {btnSync_q[0], Botao};
      noteMeta_q <= {Tom_sw, A_sw, B_sw, C_sw};
      noteSync_q <= noteMeta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pronto_q   <= pronto_d;
      fim_q      <= fim_d;
      note_q     <= note_d;
      num_q      <= num_d;
    end
  end

  assign Pronto      = pronto_q;
  assign Fim_palavra = fim_q;
  assign Tom_input   = note_q[3];
  assign A_input     = note_q[2];
  assign B_input     = note_q[1];
  assign C_input     = note_q[0];
  assign Num_notas   = num_q;

endmodule

// File: tb/tb_captura_nota.sv
// Scoreboard bench for captura_nota with a short debounce. Presses queue their expected
// capture, and a monitor checks each Pronto pulse against the front of that queue.
module tb_captura_nota;

  localparam int DEB = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Botao;
  logic       Tom_sw, A_sw, B_sw, C_sw;
  logic       Pronto, Tom_input, A_input, B_input, C_input, Fim_palavra;
  logic [3:0] Num_notas;

  int         total = 0;
  int         bad = 0;
  logic [8:0] expQ[$];
  logic [8:0] expEntry;
  logic [3:0] modelNum = 4'd0;

  captura_nota #(.DEBOUNCE_CYCLES(DEB)) dut (
    .Clk(Clk), .Reset(Reset), .Botao(Botao),
    .Tom_sw(Tom_sw), .A_sw(A_sw), .B_sw(B_sw), .C_sw(C_sw),
    .Pronto(Pronto), .Tom_input(Tom_input), .A_input(A_input),
    .B_input(B_input), .C_input(C_input), .Fim_palavra(Fim_palavra),
    .Num_notas(Num_notas)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every pulse must match the oldest queued capture; a pulse with nothing queued is an error.
  always @(negedge Clk) begin
    if (!Reset && Pronto) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", 1, 0);
      end else begin
        expEntry = expQ.pop_front();
        checkOutput("note", int'({Tom_input, A_input, B_input, C_input}), int'(expEntry[8:5]));
        checkOutput("fim_palavra", int'(Fim_palavra), int'(expEntry[4]));
        checkOutput("num_notas", int'(Num_notas), int'(expEntry[3:0]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic setNote(input logic [3:0] n);
    {Tom_sw, A_sw, B_sw, C_sw} = n;
  endtask

  task automatic pushExpect(input logic [3:0] n);
    logic sep;
    sep = (n[2:0] == 3'b000);
    if (sep) modelNum = 4'd0;
    else if (modelNum != 4'd15) modelNum = modelNum + 4'd1;
    expQ.push_back({n, sep, modelNum});
  endtask

  // Caller raises Botao just after an edge; the next edge is edge 0, pulse follows edge DEB+2.
  task automatic watchPulse();
    for (int k = 0; k < DEB + 6; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      checkOutput("pronto_timing", int'(Pronto), (k == DEB + 2) ? 1 : 0);
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_pronto"}, int'(Pronto), 0);
    checkOutput({name, "_fim"}, int'(Fim_palavra), 0);
    checkOutput({name, "_num"}, int'(Num_notas), 0);
    checkOutput({name, "_note"}, int'({Tom_input, A_input, B_input, C_input}), 0);
  endtask

  task automatic applyStimulus(input logic [3:0] n, input int hold);
    setNote(n);
    step(1);
    Botao = 1'b1;
    pushExpect(n);
    step(hold);
    Botao = 1'b0;
    step(12);
  endtask

  initial begin
    #100000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    Botao = 1'b0;
    setNote(4'b0000);
    #12;
    checkAllZero("reset");
    step(2);
    Reset = 1'b0;
    step(2);

    $display("[TB] clean press");
    setNote(4'b0011);
    step(1);
    Botao = 1'b1;
    pushExpect(4'b0011);
    watchPulse();
    step(2);
    Botao = 1'b0;
    step(12);
    checkOutput("clean_held_note", int'({Tom_input, A_input, B_input, C_input}), 3);

    $display("[TB] bounce");
    setNote(4'b0110);
    step(1);
    Botao = 1'b1; step(1);
    Botao = 1'b0; step(1);
    Botao = 1'b1; step(1);
    Botao = 1'b0; step(1);
    Botao = 1'b1;
    pushExpect(4'b0110);
    watchPulse();
    step(3);
    Botao = 1'b0; step(1);
    Botao = 1'b1; step(1);
    Botao = 1'b0; step(1);
    Botao = 1'b1; step(1);
    Botao = 1'b0; step(14);

    $display("[TB] long hold");
    setNote(4'b1010);
    step(1);
    Botao = 1'b1;
    pushExpect(4'b1010);
    step(20);
    setNote(4'b1101);
    step(80);
    Botao = 1'b0;
    step(12);
    checkOutput("hold_note", int'({Tom_input, A_input, B_input, C_input}), 10);

    $display("[TB] word separator");
    applyStimulus(4'b1000, 10);
    applyStimulus(4'b0100, 10);
    applyStimulus(4'b0101, 10);
    applyStimulus(4'b0000, 10);
    checkOutput("sep_held_note", int'({Tom_input, A_input, B_input, C_input}), 0);

    $display("[TB] saturation");
    for (int i = 0; i < 17; i++) begin
      applyStimulus({i[0], 3'(i % 7 + 1)}, 10);
    end
    checkOutput("sat_num", int'(Num_notas), 15);

    $display("[TB] reset mid-debounce");
    setNote(4'b1001);
    step(1);
    Botao = 1'b1;
    step(5);
    Reset = 1'b1;
    modelNum = 4'd0;
    #1;
    checkAllZero("midreset");
    step(2);
    Reset = 1'b0;
    pushExpect(4'b1001);
    watchPulse();
    step(2);
    Botao = 1'b0;
    step(12);

    checkOutput("queue_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
